// File: rtl/rr_arb_mux_if.sv
// ----------------------------------------------------------------------------
// rr_arb_mux_if
//
// This interface bundles the handshake and data signals of rr_arb_mux. The
// clock and the reset are not part of it.
//
// Parameters
//   WIDTH  data width of every channel word and of the output word
//   NCH    number of input channels (2..16)
//   SELW   channel-index width, derived from NCH
//
// Signals (direction as seen from the arbiter)
//   in_data    in   NCH*WIDTH  flattened channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   NCH        per-channel request
//   in_ready   out  NCH        per-channel grant/accept, combinational
//   force_en   in   1          1 = forced-select mode, 0 = round-robin
//   force_sel  in   SELW       channel index used in forced mode
//   out_data   out  WIDTH      registered selected word
//   out_valid  out  1          out_data holds an unconsumed word
//   out_ready  in   1          consumer accepts the word this cycle
//   out_ch     out  SELW       registered index of the producing channel
//
// Modports
//   master  producer/consumer side (drives requests and out_ready)
//   slave   arbiter side
// ----------------------------------------------------------------------------
interface rr_arb_mux_if #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned NCH   = 3
) ();
    localparam int unsigned SELW = $clog2(NCH);

    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 force_en;
    logic [SELW-1:0]      force_sel;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_ch;

    modport master (
        output in_data,
        output in_valid,
        output force_en,
        output force_sel,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  out_ch
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  force_en,
        input  force_sel,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output out_ch
    );
endinterface

// File: rtl/rr_arb_mux.sv
// ----------------------------------------------------------------------------
// rr_arb_mux
//
// This is an N-channel, W-bit arbitrating multiplexer with a single-entry
// registered output stage. Each cycle it grants one requesting channel and
// loads that channel's word into the output register. The grant is chosen
// either by round-robin starting at ptr, or by force_sel when force_en is set.
// The output register is refilled in the same cycle it is consumed, so
// back-to-back transfers run at one word per cycle.
//
// Parameters
//   WIDTH  data width per channel
//   NCH    number of channels, 2..16
//   SELW   channel-index width, derived from NCH (do not override)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; also masks in_ready while low
//   bus    rr_arb_mux_if.slave; handshake and data signals (see the interface)
// ----------------------------------------------------------------------------
module rr_arb_mux #(
    parameter int unsigned  WIDTH = 5,
    parameter int unsigned  NCH   = 3,
    localparam int unsigned SELW  = $clog2(NCH)
) (
    input logic         clk,
    input logic         rst_n,
    rr_arb_mux_if.slave bus
);

    // One extra bit so that ptr + offset can be compared against NCH without
    // wrapping.
    localparam logic [SELW:0]   NCH_EXT = (SELW + 1)'(NCH);
    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    // ------------------------------------------------------------------------
    // Unpack the flattened channel words
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] words [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign words[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;

    // ------------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------------
    logic            rr_found;
    logic [SELW-1:0] rr_grant;
    logic [SELW:0]   rr_idx;
    logic [SELW-1:0] force_ch;
    logic            grant_valid;
    logic [SELW-1:0] grant;
    logic            accept;
    logic            xfer;
    logic [NCH-1:0]  in_ready;

    // Scan ptr, ptr+1, ... modulo NCH. The first requester found wins.
    always_comb begin : rr_search
        rr_found = 1'b0;
        rr_grant = '0;
        rr_idx   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            rr_idx = {1'b0, ptr_q} + (SELW + 1)'(k);
            if (rr_idx >= NCH_EXT) begin
                rr_idx = rr_idx - NCH_EXT;
            end
            if (!rr_found && bus.in_valid[rr_idx[SELW-1:0]]) begin
                rr_found = 1'b1;
                rr_grant = rr_idx[SELW-1:0];
            end
        end
    end

    // An out-of-range forced index falls back to channel 0.
    assign force_ch = ({1'b0, bus.force_sel} >= NCH_EXT) ? '0 : bus.force_sel;

    always_comb begin : grant_mux
        grant       = rr_grant;
        grant_valid = rr_found;
        if (bus.force_en) begin
            grant       = force_ch;
            grant_valid = bus.in_valid[force_ch];
        end
    end

    // The output slot can take a new word when it is empty or is being drained.
    assign accept = !out_valid_q || bus.out_ready;
    assign xfer   = accept && grant_valid;

    always_comb begin : ready_decode
        in_ready = '0;
        if (rst_n && xfer) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign bus.in_ready = in_ready;

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin : next_state
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            // A refill while draining keeps out_valid high, so no bubble appears.
            out_data_d  = words[grant];
            out_ch_d    = grant;
            out_valid_d = 1'b1;
            if (!bus.force_en) begin
                ptr_d = (grant == LAST_CH) ? '0 : grant + SELW'(1);
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_regs
        if (!rst_n) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

    // ------------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------------
    a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(in_ready));

    a_stall_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_q && !bus.out_ready) |=> ($stable(out_data_q) && $stable(out_ch_q)));

    a_stall_no_ready : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_q && !bus.out_ready) |-> (in_ready == '0));

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rr_arb_mux_if #(.WIDTH(5),  .NCH(3))  b3  ();
    rr_arb_mux_if #(.WIDTH(32), .NCH(2))  b2  ();
    rr_arb_mux_if #(.WIDTH(1),  .NCH(16)) b16 ();

    rr_arb_mux #(.WIDTH(5),  .NCH(3))  dut3  (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
    rr_arb_mux #(.WIDTH(32), .NCH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
    rr_arb_mux #(.WIDTH(1),  .NCH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

    int total = 0;
    int bad   = 0;

    // Expected words in consumption order, {ch, data}
    logic [6:0]  q3  [$];
    logic [32:0] q2  [$];
    logic [4:0]  q16 [$];
    logic [6:0]  e3;
    logic [32:0] e2;
    logic [4:0]  e16;
    logic [15:0] pat16;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push3(input logic [4:0] d, input logic [1:0] ch);
        q3.push_back({ch, d});
    endtask

    initial begin
        rst_n          = 1'b0;
        pat16          = 16'hA5C3;
        b3.in_data     = {5'h03, 5'h02, 5'h01};
        b3.in_valid    = '0;
        b3.force_en    = 1'b0;
        b3.force_sel   = '0;
        b3.out_ready   = 1'b0;
        b2.in_data     = {32'h1234_5678, 32'hDEAD_BEEF};
        b2.in_valid    = '0;
        b2.force_en    = 1'b0;
        b2.force_sel   = '0;
        b2.out_ready   = 1'b0;
        b16.in_data    = pat16;
        b16.in_valid   = '0;
        b16.force_en   = 1'b0;
        b16.force_sel  = '0;
        b16.out_ready  = 1'b0;

        fork
            // Monitor: pop and compare whenever a DUT word is consumed.
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (b3.out_valid && b3.out_ready) begin
                        if (q3.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL n3_unexpected: actual=%0h required=none",
                                     {b3.out_ch, b3.out_data});
                        end else begin
                            e3 = q3.pop_front();
                            check("n3_word", 64'({b3.out_ch, b3.out_data}), 64'(e3));
                        end
                    end
                    if (b2.out_valid && b2.out_ready) begin
                        if (q2.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL n2_unexpected: actual=%0h required=none",
                                     {b2.out_ch, b2.out_data});
                        end else begin
                            e2 = q2.pop_front();
                            check("n2_word", 64'({b2.out_ch, b2.out_data}), 64'(e2));
                        end
                    end
                    if (b16.out_valid && b16.out_ready) begin
                        if (q16.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL n16_unexpected: actual=%0h required=none",
                                     {b16.out_ch, b16.out_data});
                        end else begin
                            e16 = q16.pop_front();
                            check("n16_word", 64'({b16.out_ch, b16.out_data}), 64'(e16));
                        end
                    end
                end
            end
        join_none

        // Reset state
        step();
        step();
        check("rst_valid", 64'(b3.out_valid), 64'(1'b0));
        check("rst_data",  64'(b3.out_data),  64'(5'h00));
        check("rst_ch",    64'(b3.out_ch),    64'(2'd0));
        check("rst_ready", 64'(b3.in_ready),  64'(3'b000));

        // Round-robin, all channels requesting
        rst_n        = 1'b1;
        b3.in_valid  = 3'b111;
        b3.out_ready = 1'b1;
        #1;
        check("rr_first_ready", 64'(b3.in_ready), 64'(3'b001));
        for (int i = 0; i < 2; i++) begin
            push3(5'h01, 2'd0);
            push3(5'h02, 2'd1);
            push3(5'h03, 2'd2);
        end
        repeat (6) step();

        // Sparse requests with wrap: get ptr to 2, then only ch0/ch1 request
        b3.in_valid = 3'b010;
        #1;
        check("sparse_ready_ch1", 64'(b3.in_ready), 64'(3'b010));
        push3(5'h02, 2'd1);
        step();
        b3.in_valid = 3'b011;
        #1;
        check("sparse_wrap_ready", 64'(b3.in_ready), 64'(3'b001));
        push3(5'h01, 2'd0);
        push3(5'h02, 2'd1);
        push3(5'h01, 2'd0);
        repeat (3) step();

        // Forced mode (ptr is now 1)
        b3.force_en  = 1'b1;
        b3.force_sel = 2'd2;
        b3.in_valid  = 3'b111;
        #1;
        check("force2_ready", 64'(b3.in_ready), 64'(3'b100));
        repeat (3) push3(5'h03, 2'd2);
        repeat (3) step();
        b3.force_sel = 2'd3;
        #1;
        check("force3_ready", 64'(b3.in_ready), 64'(3'b001));
        repeat (2) push3(5'h01, 2'd0);
        repeat (2) step();
        b3.force_sel = 2'd2;
        b3.in_valid  = 3'b011;
        #1;
        check("force_idle_ready", 64'(b3.in_ready), 64'(3'b000));
        step();
        check("force_idle_drained", 64'(b3.out_valid), 64'(1'b0));
        b3.force_en = 1'b0;
        b3.in_valid = 3'b111;
        #1;
        check("ptr_kept_ready", 64'(b3.in_ready), 64'(3'b010));
        push3(5'h02, 2'd1);
        step();

        // Back-pressure with (02, ch1) held; ptr is 2
        b3.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("stall_ready", 64'(b3.in_ready),  64'(3'b000));
            check("stall_data",  64'(b3.out_data),  64'(5'h02));
            check("stall_ch",    64'(b3.out_ch),    64'(2'd1));
            check("stall_valid", 64'(b3.out_valid), 64'(1'b1));
            step();
        end
        b3.out_ready = 1'b1;
        #1;
        check("unstall_ready", 64'(b3.in_ready), 64'(3'b100));
        push3(5'h03, 2'd2);
        step();
        check("no_bubble", 64'({b3.out_valid, b3.out_ch, b3.out_data}),
              64'({1'b1, 2'd2, 5'h03}));

        // Move ptr to 1, then stall and reset mid-stall
        b3.in_valid = 3'b001;
        push3(5'h01, 2'd0);
        step();
        b3.out_ready = 1'b0;
        b3.in_valid  = 3'b111;
        repeat (2) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(b3.out_valid), 64'(1'b0));
        check("midrst_data",  64'(b3.out_data),  64'(5'h00));
        check("midrst_ch",    64'(b3.out_ch),    64'(2'd0));
        check("midrst_ready", 64'(b3.in_ready),  64'(3'b000));
        q3.delete();
        repeat (2) step();
        rst_n        = 1'b1;
        b3.out_ready = 1'b1;
        #1;
        check("post_rst_ready", 64'(b3.in_ready), 64'(3'b001));
        push3(5'h01, 2'd0);
        step();
        b3.in_valid = 3'b000;
        repeat (3) step();

        // Sweep: NCH=2, WIDTH=32
        b2.in_valid  = 2'b11;
        b2.out_ready = 1'b1;
        #1;
        check("n2_first_ready", 64'(b2.in_ready), 64'(2'b01));
        for (int i = 0; i < 2; i++) begin
            q2.push_back({1'b0, 32'hDEAD_BEEF});
            q2.push_back({1'b1, 32'h1234_5678});
        end
        repeat (4) step();
        b2.in_valid = 2'b00;
        repeat (2) step();

        // Sweep: NCH=16, WIDTH=1
        b16.in_valid  = 16'hFFFF;
        b16.out_ready = 1'b1;
        #1;
        check("n16_first_ready", 64'(b16.in_ready), 64'(16'h0001));
        for (int i = 0; i < 17; i++) begin
            q16.push_back({4'(i % 16), pat16[i % 16]});
        end
        repeat (17) step();
        b16.in_valid = 16'h0000;
        repeat (3) step();

        check("q3_drained",  64'(q3.size()),  64'(0));
        check("q2_drained",  64'(q2.size()),  64'(0));
        check("q16_drained", 64'(q16.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
